// File: rtl/mrd_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mrd_stage_ctrl
// Stage sequencer and read-address generator for the ping-pong memory switch
// in front of the rdx2345 butterfly. For each FFT stage it issues one read
// beat per butterfly, then waits for that stage's write-back to land. After
// that it flips the ping-pong select and starts the next stage.
//   sw = 0 : read mem0, write mem1
//   sw = 1 : read mem1, write mem0
//
// Optional feature macro: MRD_STAGE_CTRL_TIMEOUT_EN
//   When defined, a drain watchdog aborts the transform. It fires when
//   DRAIN_TIMEOUT cycles pass in DRAIN without a wr_last, and it raises the
//   sticky err flag. When not defined, DRAIN waits forever and err is 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           1-cycle pulse, begins a transform (ignored while busy)
//   cfg_num_stages  number of stages, 0..MAX_STAGES
//   cfg_factors     per-stage radix, stage s at [s*FACTOR_W +: FACTOR_W]
//   cfg_beats       per-stage read beats, stage s at [s*CNT_W +: CNT_W]
//   rd_ready        read side accepts the current beat
//   wr_last         pulse: final write-back of the current stage landed
//   sw              ping-pong select
//   rd_valid        read beat valid
//   rd_bank_addr    beat index within the stage
//   rd_factor       radix of the current stage (0 when idle)
//   rd_twdl_numrtr  twiddle numerator for the beat
//   rd_last         final beat of the stage
//   stage_idx       current stage
//   busy            transform in progress
//   done            1-cycle pulse at transform end
//   err             sticky drain-timeout flag
// ---------------------------------------------------------------------------
module mrd_stage_ctrl #(
  parameter int MAX_STAGES    = 8,
  parameter int STAGE_W       = 3,
  parameter int FACTOR_W      = 3,
  parameter int CNT_W         = 11,
  parameter int TWDL_W        = 16
`ifdef MRD_STAGE_CTRL_TIMEOUT_EN
  , parameter int DRAIN_TIMEOUT = 1023
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [STAGE_W:0]              cfg_num_stages,
  input  logic [MAX_STAGES*FACTOR_W-1:0] cfg_factors,
  input  logic [MAX_STAGES*CNT_W-1:0]   cfg_beats,
  input  logic                          rd_ready,
  input  logic                          wr_last,
  output logic                          sw,
  output logic                          rd_valid,
  output logic [CNT_W-1:0]              rd_bank_addr,
  output logic [FACTOR_W-1:0]           rd_factor,
  output logic [TWDL_W-1:0]             rd_twdl_numrtr,
  output logic                          rd_last,
  output logic [STAGE_W-1:0]            stage_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state_q, state_d;

  logic [STAGE_W:0]               num_stages_q;
  logic [MAX_STAGES*FACTOR_W-1:0] factors_q;
  logic [MAX_STAGES*CNT_W-1:0]    beats_q;
  logic [FACTOR_W-1:0]            factor_arr [MAX_STAGES];
  logic [CNT_W-1:0]               beats_arr  [MAX_STAGES];
  logic [STAGE_W-1:0]             stage_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W-1:0]               last_idx;
  logic [TWDL_W-1:0]              twdl_q;
  logic [TWDL_W-1:0]              twdl_inc;
  logic [TWDL_W-1:0]              p_q;
  logic [FACTOR_W-1:0]            cur_factor;
  logic                           sw_q;
  logic                           done_q;
  logic                           at_last_beat;
  logic                           last_stage;
  logic                           xfer;
  logic                           launch;
  logic                           empty_done;
  logic                           advance;
  logic                           finish;
  logic                           abort;

`ifdef MRD_STAGE_CTRL_TIMEOUT_EN
  localparam int DRAIN_CW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DRAIN_CW-1:0] drain_cnt_q;
  logic                err_q;
`endif

  // The latched configuration is unpacked into per-stage arrays. The
  // current stage's radix and beat count can then be read by a plain index.
  always_comb begin
    for (int i = 0; i < MAX_STAGES; i++) begin
      factor_arr[i] = factors_q[i*FACTOR_W +: FACTOR_W];
      beats_arr[i]  = beats_q[i*CNT_W +: CNT_W];
    end
  end

  // A beat count of zero behaves like a one-beat stage. For that reason the
  // final beat index saturates at zero instead of wrapping.
  assign cur_factor   = factor_arr[stage_q];
  assign last_idx     = (beats_arr[stage_q] == '0) ? '0 : beats_arr[stage_q] - 1'b1;
  assign at_last_beat = (cnt_q == last_idx);
  assign last_stage   = ({1'b0, stage_q} == num_stages_q - 1'b1);
  assign twdl_inc     = twdl_q + 1'b1;

  // State register. Reset abandons any transform immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic plus the one-hot strobes that drive the datapath.
  // Drive the outputs from state only, so that they never depend
  // combinationally on the handshake inputs.
  always_comb begin
    state_d        = state_q;
    xfer           = 1'b0;
    launch         = 1'b0;
    empty_done     = 1'b0;
    advance        = 1'b0;
    finish         = 1'b0;
    abort          = 1'b0;
    rd_valid       = (state_q == READ);
    busy           = (state_q != IDLE);
    rd_bank_addr   = '0;
    rd_twdl_numrtr = '0;
    rd_last        = 1'b0;
    rd_factor      = busy ? cur_factor : '0;
    stage_idx      = stage_q;
    sw             = sw_q;
    done           = done_q;
`ifdef MRD_STAGE_CTRL_TIMEOUT_EN
    err            = err_q;
`else
    err            = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_num_stages == '0) begin
            empty_done = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = READ;
          end
        end
      end
      READ: begin
        rd_bank_addr   = cnt_q;
        rd_twdl_numrtr = twdl_q;
        rd_last        = at_last_beat;
        xfer           = rd_ready;
        if (rd_ready && at_last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_last) begin
          if (last_stage) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
            state_d = READ;
          end
        end
`ifdef MRD_STAGE_CTRL_TIMEOUT_EN
        else if (drain_cnt_q == DRAIN_CW'(DRAIN_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: latched configuration, beat counter, twiddle
  // numerator and its wrap period P, and the stage index. P is the product
  // of the radices of all stages that have already finished, truncated to
  // TWDL_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_stages_q <= '0;
      factors_q    <= '0;
      beats_q      <= '0;
      stage_q      <= '0;
      cnt_q        <= '0;
      twdl_q       <= '0;
      p_q          <= TWDL_W'(1);
      sw_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= empty_done | finish;
      if (launch) begin
        num_stages_q <= (cfg_num_stages > (STAGE_W+1)'(MAX_STAGES)) ?
                        (STAGE_W+1)'(MAX_STAGES) : cfg_num_stages;
        factors_q    <= cfg_factors;
        beats_q      <= cfg_beats;
        stage_q      <= '0;
        cnt_q        <= '0;
        twdl_q       <= '0;
        p_q          <= TWDL_W'(1);
        sw_q         <= 1'b0;
      end
      if (xfer) begin
        cnt_q  <= cnt_q + 1'b1;
        twdl_q <= (twdl_inc == p_q) ? '0 : twdl_inc;
      end
      if (advance) begin
        sw_q    <= ~sw_q;
        p_q     <= p_q * {{(TWDL_W-FACTOR_W){1'b0}}, cur_factor};
        stage_q <= stage_q + 1'b1;
        cnt_q   <= '0;
        twdl_q  <= '0;
      end
      if (finish || abort) begin
        sw_q    <= 1'b0;
        stage_q <= '0;
      end
    end
  end

`ifdef MRD_STAGE_CTRL_TIMEOUT_EN
  // The drain watchdog counts only while in DRAIN. It is held at zero
  // elsewhere, so every entry into DRAIN starts a fresh count. err stays set
  // until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + 1'b1;
      else                  drain_cnt_q <= '0;
      if (abort) err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mrd_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mrd_stage_ctrl
// Self-checking bench for mrd_stage_ctrl. A cycle table covers short
// single-stage cases. Hand sequences cover reset, backpressure and the
// watchdog. Randomized transforms are compared with a reference model: beat
// k of stage s must carry twiddle k mod P_s, where P_s is the product of
// the earlier radices truncated to 16 bits.
// ---------------------------------------------------------------------------
module tb_mrd_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  cfg_num_stages;
  logic [23:0] cfg_factors;
  logic [87:0] cfg_beats;
  logic        rd_ready;
  logic        wr_last;
  logic        sw;
  logic        rd_valid;
  logic [10:0] rd_bank_addr;
  logic [2:0]  rd_factor;
  logic [15:0] rd_twdl_numrtr;
  logic        rd_last;
  logic [2:0]  stage_idx;
  logic        busy;
  logic        done;
  logic        err;

  int tests;
  int failures;

  typedef struct {
    int start; int rdy; int wl; int ns; int b0;
    int v; int addr; int tw; int last; int busy; int done; int sw; int fac;
  } vec_t;

  vec_t tbl [16];

`ifdef MRD_STAGE_CTRL_TIMEOUT_EN
  mrd_stage_ctrl #(.DRAIN_TIMEOUT(16)) dut (
`else
  mrd_stage_ctrl dut (
`endif
    .clk(clk), .rst(rst), .start(start), .cfg_num_stages(cfg_num_stages),
    .cfg_factors(cfg_factors), .cfg_beats(cfg_beats), .rd_ready(rd_ready),
    .wr_last(wr_last), .sw(sw), .rd_valid(rd_valid), .rd_bank_addr(rd_bank_addr),
    .rd_factor(rd_factor), .rd_twdl_numrtr(rd_twdl_numrtr), .rd_last(rd_last),
    .stage_idx(stage_idx), .busy(busy), .done(done), .err(err)
  );

  // Free-running clock. The bench drives and samples on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something unexpected stalls the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle's inputs and move to the next falling edge. The outputs
  // seen there reflect the rising edge that consumed these inputs.
  task automatic applyStimulus(input bit s, input bit r, input bit w);
    start    = s;
    rd_ready = r;
    wr_last  = w;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " sw"}, int'(sw), 0);
    checkOutput({tag, " rd_valid"}, int'(rd_valid), 0);
    checkOutput({tag, " rd_bank_addr"}, int'(rd_bank_addr), 0);
    checkOutput({tag, " rd_factor"}, int'(rd_factor), 0);
    checkOutput({tag, " rd_twdl"}, int'(rd_twdl_numrtr), 0);
    checkOutput({tag, " rd_last"}, int'(rd_last), 0);
    checkOutput({tag, " stage_idx"}, int'(stage_idx), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " err"}, int'(err), 0);
  endtask

  // Run one whole transform and check every beat against the reference
  // model. In random mode, rd_ready stalls at random and the drain length
  // varies. Stray start and wr_last pulses are injected during READ, and the
  // cfg inputs are scrambled after the start pulse.
  task automatic runTransform(input string tag, input int ns, input logic [23:0] fac,
                              input logic [87:0] bts, input bit rnd);
    logic [15:0] p16;
    int f, eff, k, drains, exp_tw;
    bit rdy, sps, spw;
    cfg_num_stages = 4'(ns);
    cfg_factors    = fac;
    cfg_beats      = bts;
    applyStimulus(1'b1, 1'b1, 1'b0);
    if (rnd) begin
      cfg_num_stages = 4'($urandom_range(0, 8));
      cfg_factors    = 24'($urandom);
      cfg_beats      = {$urandom, $urandom, 24'($urandom)};
    end
    if (ns == 0) begin
      checkOutput({tag, " empty done"}, int'(done), 1);
      checkOutput({tag, " empty busy"}, int'(busy), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput({tag, " empty done clear"}, int'(done), 0);
      return;
    end
    p16 = 16'd1;
    for (int s = 0; s < ns; s++) begin
      f   = int'(fac[s*3 +: 3]);
      eff = (bts[s*11 +: 11] == 11'd0) ? 1 : int'(bts[s*11 +: 11]);
      k   = 0;
      while (k < eff) begin
        exp_tw = (p16 == 16'd0) ? k : k % int'(p16);
        checkOutput({tag, " rd_valid"}, int'(rd_valid), 1);
        checkOutput({tag, " rd_bank_addr"}, int'(rd_bank_addr), k);
        checkOutput({tag, " rd_twdl"}, int'(rd_twdl_numrtr), exp_tw);
        checkOutput({tag, " rd_last"}, int'(rd_last), (k == eff - 1) ? 1 : 0);
        checkOutput({tag, " rd_factor"}, int'(rd_factor), f);
        checkOutput({tag, " stage_idx"}, int'(stage_idx), s);
        checkOutput({tag, " sw"}, int'(sw), s % 2);
        checkOutput({tag, " busy"}, int'(busy), 1);
        checkOutput({tag, " done"}, int'(done), 0);
        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        sps = rnd && ($urandom_range(0, 7) == 0);
        spw = rnd && ($urandom_range(0, 7) == 0);
        applyStimulus(sps, rdy, spw);
        if (rdy) k++;
      end
      drains = rnd ? $urandom_range(0, 3) : 0;
      for (int d = 0; d <= drains; d++) begin
        checkOutput({tag, " drain rd_valid"}, int'(rd_valid), 0);
        checkOutput({tag, " drain busy"}, int'(busy), 1);
        checkOutput({tag, " drain stage_idx"}, int'(stage_idx), s);
        if (d < drains) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (s == ns - 1) begin
        checkOutput({tag, " end done"}, int'(done), 1);
        checkOutput({tag, " end busy"}, int'(busy), 0);
        checkOutput({tag, " end sw"}, int'(sw), 0);
        checkOutput({tag, " end rd_valid"}, int'(rd_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, " done one cycle"}, int'(done), 0);
      end else begin
        p16 = p16 * 16'(f);
      end
    end
  endtask

  initial begin
    logic [23:0] fac;
    logic [87:0] bts;
    int ns;
    int exp_addr;
    tests    = 0;
    failures = 0;
    rst            = 1'b1;
    start          = 1'b0;
    rd_ready       = 1'b0;
    wr_last        = 1'b0;
    cfg_num_stages = '0;
    cfg_factors    = {8{3'd4}};
    cfg_beats      = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Cycle table: one 4-beat stage, the zero-stage case, a zero-beat stage,
    // and stray wr_last and cfg changes that must be ignored.
    tbl[0]  = '{1, 1, 0, 1, 4,  1, 0, 0, 0, 1, 0, 0, 4};
    tbl[1]  = '{0, 1, 0, 1, 4,  1, 1, 0, 0, 1, 0, 0, 4};
    tbl[2]  = '{0, 1, 0, 1, 4,  1, 2, 0, 0, 1, 0, 0, 4};
    tbl[3]  = '{0, 1, 0, 1, 4,  1, 3, 0, 1, 1, 0, 0, 4};
    tbl[4]  = '{0, 1, 0, 1, 4,  0, 0, 0, 0, 1, 0, 0, 4};
    tbl[5]  = '{0, 0, 0, 3, 9,  0, 0, 0, 0, 1, 0, 0, 4};
    tbl[6]  = '{0, 0, 1, 3, 9,  0, 0, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 4,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 1, 0,  1, 0, 0, 1, 1, 0, 0, 4};
    tbl[11] = '{0, 0, 0, 1, 0,  1, 0, 0, 1, 1, 0, 0, 4};
    tbl[12] = '{0, 1, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 4};
    tbl[13] = '{0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      cfg_num_stages  = 4'(tbl[i].ns);
      cfg_beats[10:0] = 11'(tbl[i].b0);
      applyStimulus(1'(tbl[i].start), 1'(tbl[i].rdy), 1'(tbl[i].wl));
      checkOutput($sformatf("vec%0d rd_valid", i), int'(rd_valid), tbl[i].v);
      checkOutput($sformatf("vec%0d rd_bank_addr", i), int'(rd_bank_addr), tbl[i].addr);
      checkOutput($sformatf("vec%0d rd_twdl", i), int'(rd_twdl_numrtr), tbl[i].tw);
      checkOutput($sformatf("vec%0d rd_last", i), int'(rd_last), tbl[i].last);
      checkOutput($sformatf("vec%0d busy", i), int'(busy), tbl[i].busy);
      checkOutput($sformatf("vec%0d done", i), int'(done), tbl[i].done);
      checkOutput($sformatf("vec%0d sw", i), int'(sw), tbl[i].sw);
      checkOutput($sformatf("vec%0d rd_factor", i), int'(rd_factor), tbl[i].fac);
    end

    // Reset during READ with the beat counter at 5.
    cfg_num_stages = 4'd1;
    cfg_factors    = {8{3'd2}};
    cfg_beats      = '0;
    cfg_beats[10:0] = 11'd10;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pre-reset rd_bank_addr", int'(rd_bank_addr), 5);
    rst = 1'b1;
    #1;
    checkAllZero("mid-read reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runTransform("post-reset", 2, {18'd0, 3'd3, 3'd2}, {66'd0, 11'd3, 11'd4}, 1'b0);

    // Three stages with radices 4,3,5: P goes 1, 4, 12.
    runTransform("three-stage", 3, {15'd0, 3'd5, 3'd3, 3'd4},
                 {55'd0, 11'd12, 11'd20, 11'd15}, 1'b0);

    // Backpressure: rd_ready low while the beat at index 2 is presented.
    cfg_num_stages = 4'd1;
    cfg_factors    = {8{3'd2}};
    cfg_beats      = '0;
    cfg_beats[10:0] = 11'd6;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp hold rd_valid", int'(rd_valid), 1);
      checkOutput("bp hold rd_bank_addr", int'(rd_bank_addr), 2);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    exp_addr = 2;
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp resume rd_bank_addr", int'(rd_bank_addr), exp_addr);
      checkOutput("bp resume rd_last", int'(rd_last), (exp_addr == 5) ? 1 : 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      exp_addr++;
    end
    checkOutput("bp drain rd_valid", int'(rd_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bp done", int'(done), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Randomized transforms against the reference model.
    for (int t = 0; t < 8; t++) begin
      ns = (t == 0) ? 8 : $urandom_range(1, 8);
      for (int s = 0; s < 8; s++) begin
        fac[s*3 +: 3]  = 3'($urandom_range(2, 5));
        bts[s*11 +: 11] = 11'($urandom_range(0, 24));
      end
      if (t == 0) fac = {8{3'd5}};
      runTransform($sformatf("rand%0d", t), ns, fac, bts, 1'b1);
    end

`ifdef MRD_STAGE_CTRL_TIMEOUT_EN
    // Drain watchdog: withhold wr_last, so err must rise after 16 DRAIN cycles.
    cfg_num_stages = 4'd2;
    cfg_factors    = {8{3'd2}};
    cfg_beats      = {8{11'd2}};
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("timeout wait busy", int'(busy), 1);
      checkOutput("timeout wait err", int'(err), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("timeout err", int'(err), 1);
    checkOutput("timeout busy", int'(busy), 0);
    checkOutput("timeout done", int'(done), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("timeout err sticky", int'(err), 1);
    checkOutput("timeout no done", int'(done), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("timeout err cleared", int'(err), 0);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
